// File: rtl/i2c_arbiter_pkg.sv
// Shared types and I2C field widths for the I2C master arbiter.
package i2c_arbiter_pkg;

    localparam int unsigned ADDRESS_WIDTH  = 7;
    localparam int unsigned REGISTER_WIDTH = 8;
    localparam int unsigned DATA_WIDTH     = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational winner selection: round-robin from last grant, or fixed
// priority when I2C_ARBITER_FIXED_PRIORITY_EN is defined.
module i2c_rr_picker #(
    parameter int unsigned REQUESTER_COUNT = 2,
    parameter int unsigned GRANT_WIDTH     = $clog2(REQUESTER_COUNT)
) (
    input  logic [REQUESTER_COUNT-1:0] requests,
    input  logic [GRANT_WIDTH-1:0]     last_grant,
    output logic [GRANT_WIDTH-1:0]     winner,
    output logic                       any_request
);

    typedef logic [GRANT_WIDTH-1:0] idx_t;

    assign any_request = |requests;

`ifdef I2C_ARBITER_FIXED_PRIORITY_EN
    logic unused_grant;
    assign unused_grant = ^last_grant;

    // Descending scan so the lowest set index is the last assignment.
    always_comb begin
        winner = '0;
        for (int i = REQUESTER_COUNT - 1; i >= 0; i--) begin
            if (requests[i]) winner = idx_t'(i);
        end
    end
`else
    int unsigned idx;

    // Scan offsets from farthest to nearest so grant+1 has the final word.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int k = REQUESTER_COUNT; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % REQUESTER_COUNT;
            if (requests[idx]) winner = idx_t'(idx);
        end
    end
`endif

endmodule

// File: rtl/i2c_master_arbiter.sv
// Shares one I2C master among REQUESTER_COUNT requesters; grant held per transaction.
// Arbitration mode set by I2C_ARBITER_FIXED_PRIORITY_EN (undefined = round-robin).
module i2c_master_arbiter
    import i2c_arbiter_pkg::*;
#(
    parameter int unsigned REQUESTER_COUNT = 2,
    parameter int unsigned GRANT_WIDTH     = $clog2(REQUESTER_COUNT)
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [REQUESTER_COUNT-1:0]             req_ready,
    input  logic [ADDRESS_WIDTH*REQUESTER_COUNT-1:0]  req_address,
    input  logic [REQUESTER_COUNT-1:0]             req_rw,
    input  logic [REGISTER_WIDTH*REQUESTER_COUNT-1:0] req_register,
    input  logic [DATA_WIDTH*REQUESTER_COUNT-1:0]  req_data_write,
    output logic [REQUESTER_COUNT-1:0]             req_valid,
    output logic                                   req_ack,
    output logic [DATA_WIDTH-1:0]                  req_data_read,
    output logic                                   m_ready,
    output logic [ADDRESS_WIDTH-1:0]               m_address,
    output logic                                   m_rw,
    output logic [REGISTER_WIDTH-1:0]              m_register,
    output logic [DATA_WIDTH-1:0]                  m_data_write,
    input  logic                                   m_valid,
    input  logic                                   m_ack,
    input  logic [DATA_WIDTH-1:0]                  m_data_read,
    output logic                                   busy,
    output logic [GRANT_WIDTH-1:0]                 grant
);

    arb_state_t             state, state_next;
    logic [GRANT_WIDTH-1:0] winner;
    logic                   any_request;
    logic                   load;

    i2c_rr_picker #(
        .REQUESTER_COUNT(REQUESTER_COUNT),
        .GRANT_WIDTH    (GRANT_WIDTH)
    ) u_picker (
        .requests   (req_ready),
        .last_grant (grant),
        .winner     (winner),
        .any_request(any_request)
    );

    always_comb begin
        state_next = state;
        load       = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_request) begin
                    load       = 1'b1;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (m_valid) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            grant        <= GRANT_WIDTH'(REQUESTER_COUNT - 1);
            m_address    <= '0;
            m_rw         <= 1'b0;
            m_register   <= '0;
            m_data_write <= '0;
        end else begin
            state <= state_next;
            if (load) begin
                grant        <= winner;
                m_address    <= req_address[ADDRESS_WIDTH*winner +: ADDRESS_WIDTH];
                m_rw         <= req_rw[winner];
                m_register   <= req_register[REGISTER_WIDTH*winner +: REGISTER_WIDTH];
                m_data_write <= req_data_write[DATA_WIDTH*winner +: DATA_WIDTH];
            end
        end
    end

    // Request and busy follow the registered state, so m_ready drops for the IDLE cycle.
    assign m_ready = (state == BUSY);
    assign busy    = (state == BUSY);

    always_comb begin
        req_valid = '0;
        if (m_valid && state == BUSY) req_valid[grant] = 1'b1;
    end

    assign req_ack       = m_ack;
    assign req_data_read = m_data_read;

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// Directed self-checking bench for i2c_master_arbiter with two requesters.
module tb_i2c_master_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned GW = 1;

    logic          clock = 1'b0;
    logic          reset;
    logic [N-1:0]  req_ready;
    logic [7*N-1:0] req_address;
    logic [N-1:0]  req_rw;
    logic [8*N-1:0] req_register;
    logic [8*N-1:0] req_data_write;
    logic [N-1:0]  req_valid;
    logic          req_ack;
    logic [7:0]    req_data_read;
    logic          m_ready;
    logic [6:0]    m_address;
    logic          m_rw;
    logic [7:0]    m_register;
    logic [7:0]    m_data_write;
    logic          m_valid;
    logic          m_ack;
    logic [7:0]    m_data_read;
    logic          busy;
    logic [GW-1:0] grant;

    int checks = 0;
    int errors = 0;

    i2c_master_arbiter #(
        .REQUESTER_COUNT(N),
        .GRANT_WIDTH    (GW)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .req_ready     (req_ready),
        .req_address   (req_address),
        .req_rw        (req_rw),
        .req_register  (req_register),
        .req_data_write(req_data_write),
        .req_valid     (req_valid),
        .req_ack       (req_ack),
        .req_data_read (req_data_read),
        .m_ready       (m_ready),
        .m_address     (m_address),
        .m_rw          (m_rw),
        .m_register    (m_register),
        .m_data_write  (m_data_write),
        .m_valid       (m_valid),
        .m_ack         (m_ack),
        .m_data_read   (m_data_read),
        .busy          (busy),
        .grant         (grant)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        int exp_owner;
        reset          = 1'b1;
        req_ready      = '0;
        req_address    = '0;
        req_rw         = '0;
        req_register   = '0;
        req_data_write = '0;
        m_valid        = 1'b0;
        m_ack          = 1'b0;
        m_data_read    = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_m_ready", 32'(m_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd1);
        check("rst_m_address", 32'(m_address), 32'd0);
        check("rst_req_valid", 32'(req_valid), 32'd0);

        // m_valid while idle must not pulse anyone
        m_valid = 1'b1;
        #1;
        check("idle_mvalid_ignored", 32'(req_valid), 32'd0);
        tick();
        m_valid = 1'b0;
        check("idle_mvalid_state", 32'(busy), 32'd0);

        // Single write from requester 0
        req_ready            = 2'b01;
        req_address[6:0]     = 7'h5E;
        req_register[7:0]    = 8'h0A;
        req_data_write[7:0]  = 8'h0C;
        req_rw[0]            = 1'b0;
        check("single_not_yet", 32'(m_ready), 32'd0);
        tick();
        check("single_m_ready", 32'(m_ready), 32'd1);
        check("single_busy", 32'(busy), 32'd1);
        check("single_grant", 32'(grant), 32'd0);
        check("single_addr", 32'(m_address), 32'h5E);
        check("single_reg", 32'(m_register), 32'h0A);
        check("single_data", 32'(m_data_write), 32'h0C);
        check("single_rw", 32'(m_rw), 32'd0);
        tick();
        check("single_no_early_valid", 32'(req_valid), 32'd0);
        m_valid = 1'b1;
        m_ack   = 1'b0;
        #1;
        check("single_req_valid", 32'(req_valid), 32'b01);
        check("single_req_ack", 32'(req_ack), 32'd0);
        tick();
        m_valid   = 1'b0;
        req_ready = 2'b00;
        check("single_done_m_ready", 32'(m_ready), 32'd0);
        check("single_done_busy", 32'(busy), 32'd0);

        // Contention from reset state
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_address[6:0]  = 7'h10;
        req_address[13:7] = 7'h20;
        req_ready         = 2'b11;
        for (int k = 0; k < 4; k++) begin
`ifdef I2C_ARBITER_FIXED_PRIORITY_EN
            exp_owner = 0;
`else
            exp_owner = k % 2;
`endif
            tick();
            check("cont_m_ready", 32'(m_ready), 32'd1);
            check("cont_grant", 32'(grant), 32'(exp_owner));
            check("cont_addr", 32'(m_address), (exp_owner == 0) ? 32'h10 : 32'h20);
            for (int c = 0; c < 4; c++) tick();
            m_valid = 1'b1;
            #1;
            check("cont_req_valid", 32'(req_valid), 32'(1 << exp_owner));
            tick();
            m_valid = 1'b0;
            check("cont_gap_m_ready", 32'(m_ready), 32'd0);
        end
        // Drop requester 0 during the idle cycle; requester 1 must win
        req_ready = 2'b10;
        tick();
        check("drop0_grant", 32'(grant), 32'd1);
        check("drop0_addr", 32'(m_address), 32'h20);
        m_valid = 1'b1;
        #1;
        check("drop0_req_valid", 32'(req_valid), 32'b10);
        tick();
        m_valid   = 1'b0;
        req_ready = 2'b00;
        tick();

        // Read by requester 1, ACK then NACK on a chained request
        req_address[13:7]  = 7'h54;
        req_register[15:8] = 8'h21;
        req_rw             = 2'b10;
        req_ready          = 2'b10;
        tick();
        check("rd_addr", 32'(m_address), 32'h54);
        check("rd_reg", 32'(m_register), 32'h21);
        check("rd_rw", 32'(m_rw), 32'd1);
        m_valid     = 1'b1;
        m_ack       = 1'b0;
        m_data_read = 8'h5A;
        #1;
        check("rd_req_valid", 32'(req_valid), 32'b10);
        check("rd_data", 32'(req_data_read), 32'h5A);
        check("rd_ack0", 32'(req_ack), 32'd0);
        tick();
        m_valid = 1'b0;
        check("rd_chain_gap", 32'(m_ready), 32'd0);
        tick();
        check("rd_chain_m_ready", 32'(m_ready), 32'd1);
        m_valid = 1'b1;
        m_ack   = 1'b1;
        #1;
        check("nack_req_valid", 32'(req_valid), 32'b10);
        check("nack_ack", 32'(req_ack), 32'd1);
        tick();
        m_valid   = 1'b0;
        m_ack     = 1'b0;
        req_ready = 2'b00;
        req_rw    = 2'b00;
        tick();

        // Field stability while busy
        req_address[6:0]    = 7'h33;
        req_register[7:0]   = 8'h44;
        req_data_write[7:0] = 8'h55;
        req_ready           = 2'b01;
        tick();
        check("stab_addr0", 32'(m_address), 32'h33);
        req_address[6:0] = 7'h7F;
        req_ready        = 2'b00;
        tick();
        check("stab_addr1", 32'(m_address), 32'h33);
        check("stab_reg", 32'(m_register), 32'h44);
        check("stab_data", 32'(m_data_write), 32'h55);
        check("stab_busy", 32'(busy), 32'd1);
        m_valid = 1'b1;
        #1;
        check("stab_req_valid", 32'(req_valid), 32'b01);
        tick();
        m_valid = 1'b0;

        // Reset two cycles into a transaction
        req_ready = 2'b10;
        tick();
        check("rstmid_busy_before", 32'(busy), 32'd1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("rstmid_m_ready", 32'(m_ready), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        check("rstmid_grant", 32'(grant), 32'd1);
        check("rstmid_addr", 32'(m_address), 32'd0);
        reset     = 1'b0;
        req_ready = 2'b00;
        m_valid   = 1'b1;
        #1;
        check("rstmid_no_valid", 32'(req_valid), 32'd0);
        tick();
        m_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
